// File: rtl/palette_commit_ctrl_if.sv
// Host-side write channel of the palette controller: one (index, RGB) update per
// accepted valid/ready handshake.
interface palette_commit_ctrl_if #(
    parameter int IDX_W = 4
) ();
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic [23:0]      wr_rgb;

    modport master (
        output wr_valid,
        output wr_index,
        output wr_rgb,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_index,
        input  wr_rgb,
        output wr_ready
    );
endinterface

// File: rtl/palette_commit_ctrl.sv
// Colour palette with vblank-gated commit of queued host writes and a
// one-cycle registered per-pixel lookup.
module palette_commit_ctrl #(
    parameter  int IDX_W      = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    palette_commit_ctrl_if.slave wr,
    input  logic                 vblank,
    input  logic [IDX_W-1:0]     pix_index,
    output logic [7:0]           VGA_R,
    output logic [7:0]           VGA_G,
    output logic [7:0]           VGA_B,
    output logic [CNT_W-1:0]     pending_count,
    output logic                 commit_done
);

    localparam int NUM_COLORS = 2 ** IDX_W;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [1:0]         rst_sync_q;
    logic               rst_int_n;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ready_q;
    logic               done_q;
    logic [23:0]        rgb_q;
    logic               push;
    logic               pop;
    logic [IDX_W-1:0]   fifo_idx_q [FIFO_DEPTH];
    logic [23:0]        fifo_rgb_q [FIFO_DEPTH];
    logic [23:0]        palette_q  [NUM_COLORS];

    // Pointer advance that wraps at FIFO_DEPTH, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    assign push = wr.wr_valid && ready_q;

    // Next-state: commits happen only in COMMIT while vblank is high.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vblank && (count_q != {CNT_W{1'b0}})) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (!vblank) begin
                    state_d = ST_IDLE;
                end else if (count_q != {CNT_W{1'b0}}) begin
                    pop = 1'b1;
                    if ((count_q == CNT_W'(1)) && !push) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; commit_done is high exactly while the FSM sits in DRAIN.
    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d < CNT_W'(FIFO_DEPTH));
            done_q   <= (state_d == ST_DRAIN);
        end
    end

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_idx_q[i] <= {IDX_W{1'b0}};
                fifo_rgb_q[i] <= 24'h000000;
            end
        end else if (push) begin
            fifo_idx_q[wr_ptr_q] <= wr.wr_index;
            fifo_rgb_q[wr_ptr_q] <= wr.wr_rgb;
        end
    end

    // Palette storage; a reset mid-commit restores the power-on colours.
    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                palette_q[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
            end
        end else if (pop) begin
            palette_q[fifo_idx_q[rd_ptr_q]] <= fifo_rgb_q[rd_ptr_q];
        end
    end

    // Lookup reads the pre-commit array, so a same-cycle commit shows next cycle.
    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= palette_q[pix_index];
        end
    end

    assign wr.wr_ready    = ready_q;
    assign pending_count  = count_q;
    assign commit_done    = done_q;
    assign VGA_R          = rgb_q[23:16];
    assign VGA_G          = rgb_q[15:8];
    assign VGA_B          = rgb_q[7:0];

endmodule
